// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: reset-vector load, opcode fetch, extension-word fetch, execute handshake.
// Optional bus-timeout watchdog enabled by defining FETCH_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RST_VEC   | read reset vector at 16'hFFFE, load it into the PC
// FETCH_OP  | read opcode at PC into ir, advance PC by 2
// DECODE    | single cycle: sample ext_cnt, choose FETCH_EXT or EXEC
// FETCH_EXT | read ext_cnt extension words at PC, advance PC per word
// EXEC      | wait for exec_done, optionally redirect PC to CALC_OUT
module fetch_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] reg_PC_in,
   output logic [2:0]  pc_sel,
   output logic [15:0] reg_PC_out,
   output logic [15:0] MAB,
   output logic        mem_rd_req,
   input  logic        mem_rd_ack,
   input  logic [15:0] MDB,
   output logic [15:0] ir,
   output logic        ir_valid,
   input  logic [1:0]  ext_cnt,
   output logic [15:0] ext_word,
   output logic        ext_valid,
   input  logic        exec_done,
   input  logic        branch_taken,
   output logic        fetch_err
);

   localparam logic [2:0] SEL_NEXT = 3'd0;
   localparam logic [2:0] SEL_HOLD = 3'd1;
   localparam logic [2:0] SEL_CALC = 3'd2;
   localparam logic [2:0] SEL_MDB  = 3'd4;

   localparam logic [15:0] RESET_VECTOR = 16'hFFFE;

   typedef enum logic [2:0] {
      RST_VEC   = 3'd0,
      FETCH_OP  = 3'd1,
      DECODE    = 3'd2,
      FETCH_EXT = 3'd3,
      EXEC      = 3'd4
   } state_t;

   state_t     state;
   logic [1:0] word_cnt;
   logic       ack_ok;
   logic       timeout;
   logic       unused_pc_lsb;

   // The request is only ever raised inside a fetch state, so it qualifies the ack.
   assign ack_ok        = mem_rd_req & mem_rd_ack;
   assign unused_pc_lsb = reg_PC_in[0];

`ifdef FETCH_TIMEOUT_EN
   logic [3:0] tmo_cnt;

   assign timeout = mem_rd_req & ~mem_rd_ack & (tmo_cnt == 4'd14);

   // Every state is entered with the request low, so clearing on !mem_rd_req covers state entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt   <= 4'd0;
         fetch_err <= 1'b0;
      end else if (timeout) begin
         tmo_cnt   <= 4'd0;
         fetch_err <= 1'b1;
      end else if (ack_ok || !mem_rd_req) begin
         tmo_cnt <= 4'd0;
      end else begin
         tmo_cnt <= tmo_cnt + 4'd1;
      end
   end
`else
   assign timeout   = 1'b0;
   assign fetch_err = 1'b0;
`endif

   // The PC select must react in the ack cycle itself so the mux result lands on that edge.
   always_comb begin
      pc_sel = SEL_HOLD;
      case (state)
         RST_VEC:   if (ack_ok) pc_sel = SEL_MDB;
         FETCH_OP:  if (ack_ok) pc_sel = SEL_NEXT;
         FETCH_EXT: if (ack_ok) pc_sel = SEL_NEXT;
         EXEC:      if (exec_done && branch_taken) pc_sel = SEL_CALC;
         default:   pc_sel = SEL_HOLD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RST_VEC;
         reg_PC_out <= 16'h0000;
         MAB        <= 16'h0000;
         mem_rd_req <= 1'b0;
         ir         <= 16'h0000;
         ir_valid   <= 1'b0;
         ext_word   <= 16'h0000;
         ext_valid  <= 1'b0;
         word_cnt   <= 2'd0;
      end else begin
         reg_PC_out <= {reg_PC_in[15:1], 1'b0};
         ir_valid   <= 1'b0;
         ext_valid  <= 1'b0;
         if (timeout) begin
            mem_rd_req <= 1'b0;
            state      <= RST_VEC;
         end else begin
            case (state)
               RST_VEC: begin
                  if (!mem_rd_req) begin
                     mem_rd_req <= 1'b1;
                     MAB        <= RESET_VECTOR;
                  end else if (mem_rd_ack) begin
                     mem_rd_req <= 1'b0;
                     state      <= FETCH_OP;
                  end
               end
               FETCH_OP: begin
                  if (!mem_rd_req) begin
                     mem_rd_req <= 1'b1;
                     MAB        <= reg_PC_out;
                  end else if (mem_rd_ack) begin
                     mem_rd_req <= 1'b0;
                     ir         <= MDB;
                     ir_valid   <= 1'b1;
                     state      <= DECODE;
                  end
               end
               DECODE: begin
                  if (ext_cnt == 2'd0) begin
                     state <= EXEC;
                  end else begin
                     word_cnt <= (ext_cnt == 2'd3) ? 2'd2 : ext_cnt;
                     state    <= FETCH_EXT;
                  end
               end
               FETCH_EXT: begin
                  if (!mem_rd_req) begin
                     mem_rd_req <= 1'b1;
                     MAB        <= reg_PC_out;
                  end else if (mem_rd_ack) begin
                     mem_rd_req <= 1'b0;
                     ext_word   <= MDB;
                     ext_valid  <= 1'b1;
                     word_cnt   <= word_cnt - 2'd1;
                     if (word_cnt == 2'd1) state <= EXEC;
                  end
               end
               EXEC: begin
                  if (exec_done) state <= FETCH_OP;
               end
               default: begin
                  mem_rd_req <= 1'b0;
                  state      <= RST_VEC;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC select mux around the DUT.
// Covers both builds; the timeout section follows FETCH_TIMEOUT_EN.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic [15:0] reg_PC_in;
   logic [2:0]  pc_sel;
   logic [15:0] reg_PC_out;
   logic [15:0] MAB;
   logic        mem_rd_req;
   logic        mem_rd_ack;
   logic [15:0] MDB;
   logic [15:0] ir;
   logic        ir_valid;
   logic [1:0]  ext_cnt;
   logic [15:0] ext_word;
   logic        ext_valid;
   logic        exec_done;
   logic        branch_taken;
   logic        fetch_err;
   logic [15:0] calc_out;

   int checks = 0;
   int errors = 0;

   fetch_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .reg_PC_in    (reg_PC_in),
      .pc_sel       (pc_sel),
      .reg_PC_out   (reg_PC_out),
      .MAB          (MAB),
      .mem_rd_req   (mem_rd_req),
      .mem_rd_ack   (mem_rd_ack),
      .MDB          (MDB),
      .ir           (ir),
      .ir_valid     (ir_valid),
      .ext_cnt      (ext_cnt),
      .ext_word     (ext_word),
      .ext_valid    (ext_valid),
      .exec_done    (exec_done),
      .branch_taken (branch_taken),
      .fetch_err    (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      case (pc_sel)
         3'd0:    reg_PC_in = reg_PC_out + 16'd2;
         3'd1:    reg_PC_in = reg_PC_out;
         3'd2:    reg_PC_in = calc_out;
         3'd3:    reg_PC_in = {MDB[14:0], 1'b0};
         3'd4:    reg_PC_in = MDB;
         default: reg_PC_in = reg_PC_out;
      endcase
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input logic [15:0] addr, input logic [15:0] data,
                          input logic [2:0] sel, input string tag);
      int n;
      n = 0;
      while (mem_rd_req !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk({tag, " req"}, 16'(mem_rd_req), 16'h0001);
      chk({tag, " MAB"}, MAB, addr);
      mem_rd_ack = 1'b1;
      MDB        = data;
      #1;
      chk({tag, " pc_sel"}, 16'(pc_sel), 16'(sel));
      @(negedge clk);
      mem_rd_ack = 1'b0;
      MDB        = 16'h0000;
      chk({tag, " req drop"}, 16'(mem_rd_req), 16'h0000);
   endtask

   task automatic exec_step(input logic br, input logic [15:0] calc,
                            input logic [2:0] sel, input string tag);
      calc_out     = calc;
      exec_done    = 1'b1;
      branch_taken = br;
      #1;
      chk({tag, " pc_sel"}, 16'(pc_sel), 16'(sel));
      @(negedge clk);
      exec_done    = 1'b0;
      branch_taken = 1'b0;
   endtask

   initial begin
      int n;
      rst_n        = 1'b0;
      mem_rd_ack   = 1'b1;
      MDB          = 16'hAAAA;
      ext_cnt      = 2'd0;
      exec_done    = 1'b0;
      branch_taken = 1'b0;
      calc_out     = 16'h0000;
      repeat (3) @(negedge clk);

      chk("rst pc",        reg_PC_out, 16'h0000);
      chk("rst ir",        ir, 16'h0000);
      chk("rst ext_word",  ext_word, 16'h0000);
      chk("rst req",       16'(mem_rd_req), 16'h0000);
      chk("rst pc_sel",    16'(pc_sel), 16'h0001);
      chk("rst ir_valid",  16'(ir_valid), 16'h0000);
      chk("rst ext_valid", 16'(ext_valid), 16'h0000);
      chk("rst fetch_err", 16'(fetch_err), 16'h0000);

      mem_rd_ack = 1'b0;
      MDB        = 16'h0000;
      rst_n      = 1'b1;
      #1;
      chk("release req low", 16'(mem_rd_req), 16'h0000);
      @(negedge clk);
      chk("first req", 16'(mem_rd_req), 16'h0001);
      chk("first MAB", MAB, 16'hFFFE);

      do_read(16'hFFFE, 16'hC000, 3'd4, "vec");
      chk("vec pc", reg_PC_out, 16'hC000);

      // opcode without extension, not taken
      ext_cnt = 2'd0;
      do_read(16'hC000, 16'h4303, 3'd0, "op1");
      chk("op1 ir_valid", 16'(ir_valid), 16'h0001);
      chk("op1 ir", ir, 16'h4303);
      chk("op1 pc", reg_PC_out, 16'hC002);
      @(negedge clk);
      chk("op1 ir_valid pulse", 16'(ir_valid), 16'h0000);
      exec_step(1'b0, 16'h1111, 3'd1, "ex1");
      chk("ex1 pc", reg_PC_out, 16'hC002);

      // taken branch back to C000
      do_read(16'hC002, 16'h1000, 3'd0, "op2");
      @(negedge clk);
      exec_step(1'b1, 16'hC000, 3'd2, "ex2");

      // ext_cnt=3 behaves as two words
      ext_cnt = 2'd3;
      do_read(16'hC000, 16'h5555, 3'd0, "op3");
      chk("op3 ir", ir, 16'h5555);
      do_read(16'hC002, 16'h1234, 3'd0, "ext1");
      chk("ext1 valid", 16'(ext_valid), 16'h0001);
      chk("ext1 word", ext_word, 16'h1234);
      ext_cnt = 2'd0;
      @(negedge clk);
      chk("ext1 valid pulse", 16'(ext_valid), 16'h0000);
      do_read(16'hC004, 16'h5678, 3'd0, "ext2");
      chk("ext2 valid", 16'(ext_valid), 16'h0001);
      chk("ext2 word", ext_word, 16'h5678);
      chk("ext2 pc", reg_PC_out, 16'hC006);
      exec_step(1'b0, 16'h0000, 3'd1, "ex3");

      do_read(16'hC006, 16'h4304, 3'd0, "op4");
      chk("op4 ir_valid", 16'(ir_valid), 16'h0001);
      chk("op4 ir", ir, 16'h4304);
      @(negedge clk);
      exec_step(1'b1, 16'hD000, 3'd2, "ex4");

      // stray ack and branch_taken without exec_done must be ignored
      do_read(16'hD000, 16'h4305, 3'd0, "op5");
      @(negedge clk);
      branch_taken = 1'b1;
      mem_rd_ack   = 1'b1;
      MDB          = 16'h9999;
      #1;
      chk("ign pc_sel", 16'(pc_sel), 16'h0001);
      @(negedge clk);
      branch_taken = 1'b0;
      mem_rd_ack   = 1'b0;
      MDB          = 16'h0000;
      chk("ign pc", reg_PC_out, 16'hD002);
      chk("ign req", 16'(mem_rd_req), 16'h0000);
      chk("ign ir", ir, 16'h4305);
      exec_step(1'b1, 16'hFFFE, 3'd2, "ex5");

      // wrap from FFFE to 0000
      do_read(16'hFFFE, 16'h4306, 3'd0, "op6");
      chk("wrap pc", reg_PC_out, 16'h0000);
      @(negedge clk);
      exec_step(1'b0, 16'h0000, 3'd1, "ex6");

      n = 0;
      while (mem_rd_req !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("op7 req", 16'(mem_rd_req), 16'h0001);
      chk("op7 MAB", MAB, 16'h0000);

`ifdef FETCH_TIMEOUT_EN
      repeat (14) @(negedge clk);
      chk("tmo pre err", 16'(fetch_err), 16'h0000);
      chk("tmo pre req", 16'(mem_rd_req), 16'h0001);
      @(negedge clk);
      chk("tmo err", 16'(fetch_err), 16'h0001);
      chk("tmo req drop", 16'(mem_rd_req), 16'h0000);
      @(negedge clk);
      chk("tmo re-req", 16'(mem_rd_req), 16'h0001);
      chk("tmo vec MAB", MAB, 16'hFFFE);
      do_read(16'hFFFE, 16'hC000, 3'd4, "vec2");
      chk("tmo err sticky", 16'(fetch_err), 16'h0001);
`else
      repeat (30) @(negedge clk);
      chk("hold req", 16'(mem_rd_req), 16'h0001);
      chk("hold MAB", MAB, 16'h0000);
      chk("hold err", 16'(fetch_err), 16'h0000);
      do_read(16'h0000, 16'h4307, 3'd0, "op7");
      @(negedge clk);
      exec_step(1'b0, 16'h0000, 3'd1, "ex7");
`endif

      // reset in the middle of an acked opcode read
      n = 0;
      while (mem_rd_req !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("mid req", 16'(mem_rd_req), 16'h0001);
      mem_rd_ack = 1'b1;
      MDB        = 16'hBEEF;
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid ir", ir, 16'h0000);
      chk("mid pc", reg_PC_out, 16'h0000);
      chk("mid req low", 16'(mem_rd_req), 16'h0000);
      @(negedge clk);
      chk("mid ir_valid", 16'(ir_valid), 16'h0000);
      chk("mid ir hold", ir, 16'h0000);
      mem_rd_ack = 1'b0;
      MDB        = 16'h0000;
      rst_n      = 1'b1;
      @(negedge clk);
      chk("mid re-req", 16'(mem_rd_req), 16'h0001);
      chk("mid vec MAB", MAB, 16'hFFFE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
